// File: rtl/reg_file_sb.sv
// Integer register file with a pending-write scoreboard and a registered valid/ready operand port.
// Reads stall on an outstanding producer unless its write-back lands in the same cycle (bypass).
module reg_file_sb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            rd_req_valid,
    output logic            rd_req_ready,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            rd_resp_valid,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,

    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,

    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,

    output logic [NREG-1:0] pending
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    logic            wb_fire;
    logic            issue_fire;
    logic            rd_fire;
    logic            haz1;
    logic            haz2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    assign wb_fire     = wb_en && (wb_addr != '0);
    assign issue_ready = !pending_q[issue_rd];
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);
    assign pending     = pending_q;

    // Ready depends only on addresses and write-back, never on rd_req_valid.
    always_comb begin
        haz1 = (rs1_addr != '0) && pending_q[rs1_addr] && !(wb_en && (wb_addr == rs1_addr));
        haz2 = (rs2_addr != '0) && pending_q[rs2_addr] && !(wb_en && (wb_addr == rs2_addr));
        rd_req_ready = !(haz1 || haz2);
        rd_fire      = rd_req_valid && rd_req_ready;
    end

    always_comb begin
        rs1_val = regs[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_val = '0;
        end else if (wb_en && (wb_addr == rs1_addr)) begin
            rs1_val = wb_data;
        end

        rs2_val = regs[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_val = '0;
        end else if (wb_en && (wb_addr == rs2_addr)) begin
            rs2_val = wb_data;
        end
    end

    // Clear on write-back first so a same-cycle accepted issue to that register wins.
    always_comb begin
        pending_d = pending_q;
        if (wb_en) begin
            pending_d[wb_addr] = 1'b0;
        end
        if (issue_fire) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_fire) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_resp_valid <= 1'b0;
            rs1_data      <= '0;
            rs2_data      <= '0;
        end else begin
            rd_resp_valid <= rd_fire;
            if (rd_fire) begin
                rs1_data <= rs1_val;
                rs2_data <= rs2_val;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: stimulus pushes expected operand pairs, a monitor pops
// and compares them whenever a registered response appears.
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rd_resp_valid;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] pending;

    int checks;
    int errors;
    logic [63:0] sb_q [$];

    reg_file_sb #(
        .XLEN (32),
        .NREG (32),
        .AW   (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rd_resp_valid (rd_resp_valid),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_ready   (issue_ready),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .pending       (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue a read; if accepted, the expected pair is queued for the monitor.
    task automatic rd(input logic [4:0] a, input logic [4:0] b,
                      input logic [31:0] e1, input logic [31:0] e2);
        rd_req_valid = 1'b1;
        rs1_addr     = a;
        rs2_addr     = b;
        #1;
        check("rd_req_ready", {31'b0, rd_req_ready}, 32'd1);
        if (rd_req_ready) sb_q.push_back({e1, e2});
    endtask

    always @(negedge clk) begin
        if (!rst && rd_resp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got rs1=%h rs2=%h expected no response",
                         rs1_data, rs2_data);
            end else begin
                logic [63:0] exp;
                exp = sb_q.pop_front();
                check("resp_rs1", rs1_data, exp[63:32]);
                check("resp_rs2", rs2_data, exp[31:0]);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        rd_req_valid = 1'b0; rs1_addr = '0; rs2_addr = '0;
        issue_valid = 1'b0; issue_rd = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;

        // 1: reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_resp_valid", {31'b0, rd_resp_valid}, 32'd0);
        check("rst_rs1_data", rs1_data, 32'd0);
        check("rst_pending", pending, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rd(5'd5, 5'd0, 32'd0, 32'd0);

        // 2: write then read
        @(negedge clk); rd_req_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
        @(negedge clk); wb_en = 1'b0; rd(5'd3, 5'd0, 32'hDEADBEEF, 32'd0);

        // 3: stall on pending x7, released by same-cycle write-back with bypass
        @(negedge clk); rd_req_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1 check("issue7_ready", {31'b0, issue_ready}, 32'd1);
        @(negedge clk); issue_valid = 1'b0;
        rd_req_valid = 1'b1; rs1_addr = 5'd7; rs2_addr = 5'd0;
        #1;
        check("pending7_set", {31'b0, pending[7]}, 32'd1);
        check("issue7_busy", {31'b0, issue_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("stall_ready", {31'b0, rd_req_ready}, 32'd0);
            @(negedge clk); #1;
        end
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h55;
        rd(5'd7, 5'd0, 32'h55, 32'd0);
        @(negedge clk); wb_en = 1'b0; rd_req_valid = 1'b0;
        #1 check("pending7_clr", {31'b0, pending[7]}, 32'd0);

        // 4: x0 ignores writes and issues
        @(negedge clk);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1 check("issue0_ready", {31'b0, issue_ready}, 32'd1);
        @(negedge clk); wb_en = 1'b0; issue_valid = 1'b0;
        #1 check("pending_x0", pending, 32'd0);
        rd(5'd0, 5'd0, 32'd0, 32'd0);
        check("issue0_still_ready", {31'b0, issue_ready}, 32'd1);

        // Read and issue of the same register in one cycle: reader sees pre-issue state
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd3;
        rd(5'd3, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF);
        @(negedge clk); rd_req_valid = 1'b0; issue_valid = 1'b0;
        #1 check("pending3_set", {31'b0, pending[3]}, 32'd1);

        // 5: issue/write-back collision on x9
        @(negedge clk); issue_valid = 1'b1; issue_rd = 5'd9;
        @(negedge clk); issue_valid = 1'b0;
        #1 check("pending9_set", {31'b0, pending[9]}, 32'd1);
        @(negedge clk);
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h11;
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1 check("issue9_collide", {31'b0, issue_ready}, 32'd0);
        @(negedge clk); wb_en = 1'b0;
        #1;
        check("pending9_clr", {31'b0, pending[9]}, 32'd0);
        check("issue9_retry", {31'b0, issue_ready}, 32'd1);
        @(negedge clk); issue_valid = 1'b0;
        rd_req_valid = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd9;
        #1;
        check("pending9_reset", {31'b0, pending[9]}, 32'd1);
        check("regs9", dut.regs[9], 32'h11);
        check("rs2_hazard", {31'b0, rd_req_ready}, 32'd0);

        // 6: back-to-back reads, then async reset between edges
        @(negedge clk); rd_req_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h1234_5678;
        @(negedge clk); wb_en = 1'b0; rd(5'd12, 5'd12, 32'h1234_5678, 32'h1234_5678);
        @(negedge clk); rd(5'd0, 5'd12, 32'd0, 32'h1234_5678);
        @(negedge clk); rd(5'd12, 5'd0, 32'h1234_5678, 32'd0);
        @(posedge clk); #2;
        rst = 1'b1; rd_req_valid = 1'b0;
        #1;
        check("async_valid", {31'b0, rd_resp_valid}, 32'd0);
        check("async_rs1", rs1_data, 32'd0);
        check("async_rs2", rs2_data, 32'd0);
        sb_q.delete();
        @(negedge clk); @(negedge clk); rst = 1'b0;
        #1 check("post_rst_pending", pending, 32'd0);
        @(negedge clk); rd(5'd12, 5'd9, 32'd0, 32'd0);
        @(negedge clk); rd_req_valid = 1'b0;
        repeat (2) @(negedge clk);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_resp: got %0d outstanding expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
